// File: rtl/alu_issue_arbiter.sv
// -----------------------------------------------------------------------------
// alu_issue_arbiter
//
// Registered issue stage in front of the shared ALU. Each cycle it chooses
// between the main pipeline's stage-1 ALU op and an auxiliary requester
// (debug/interrupt microsequencer). It decodes the winning 4-bit op through
// DECODE_ROM into the 8-bit ALU control word and drives the ALU active strobe
// one cycle later. A starvation counter makes sure a waiting aux request is
// forced through after STARVE_LIMIT consecutive pipeline grants.
//
// Parameters
//   STARVE_LIMIT  pipeline grants allowed while aux waits (legal 1..15)
//   DECODE_ROM    op-to-control table, entry n = DECODE_ROM[8n+7:8n]
//
// Ports
//   Clock         in   system clock, rising edge
//   Reset         in   asynchronous, active-high reset
//   PipeAluReq    in   pipeline has an ALU op this cycle
//   PipeAluOp     in   pipeline ALU op [3:0]
//   PipeAluStall  out  comb: pipeline op not accepted, hold it
//   AuxAluReq     in   aux requester has an op (held until granted)
//   AuxAluOp      in   aux ALU op [3:0]
//   AuxAluGnt     out  comb: one-cycle accept pulse for aux
//   AluCtrl       out  registered control word AC0..AC7
//   AluActive     out  registered: ALU performs the issued op this cycle
//   AluOwner      out  registered: 00 idle, 01 pipeline, 10 aux
// -----------------------------------------------------------------------------
module alu_issue_arbiter #(
   parameter int unsigned  STARVE_LIMIT = 4,
   parameter logic [127:0] DECODE_ROM   = 128'hFFEEDDCCBBAA99887766554433221100
) (
   input  logic       Clock,
   input  logic       Reset,
   input  logic       PipeAluReq,
   input  logic [3:0] PipeAluOp,
   output logic       PipeAluStall,
   input  logic       AuxAluReq,
   input  logic [3:0] AuxAluOp,
   output logic       AuxAluGnt,
   output logic [7:0] AluCtrl,
   output logic       AluActive,
   output logic [1:0] AluOwner
);

   // Decision encoding doubles as the AluOwner code.
   typedef enum logic [1:0] {
      DEC_IDLE = 2'b00,
      DEC_PIPE = 2'b01,
      DEC_AUX  = 2'b10
   } decision_e;

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   decision_e  decision;
   logic [3:0] win_op;
   logic       aux_forced;

   logic [7:0] ctrl_q,   ctrl_d;
   logic       active_q, active_d;
   logic [1:0] owner_q,  owner_d;
   logic [3:0] starve_q, starve_d;

   always_comb begin
      decision   = DEC_IDLE;
      win_op     = PipeAluOp;
      aux_forced = AuxAluReq && (starve_q == LIMIT);

      // Grants are suppressed while Reset is held so nothing is accepted
      // that the reset would then silently drop.
      if (!Reset) begin
         if (AuxAluReq && (!PipeAluReq || aux_forced)) begin
            decision = DEC_AUX;
            win_op   = AuxAluOp;
         end else if (PipeAluReq) begin
            decision = DEC_PIPE;
         end
      end

      AuxAluGnt    = (decision == DEC_AUX);
      PipeAluStall = PipeAluReq && (decision == DEC_AUX);

      // AluCtrl holds through idle cycles to avoid needless toggling.
      ctrl_d   = ctrl_q;
      active_d = 1'b0;
      owner_d  = decision;
      if (decision != DEC_IDLE) begin
         ctrl_d   = DECODE_ROM[{win_op, 3'b000} +: 8];
         active_d = 1'b1;
      end

      // Counts pipeline wins while aux waits. Saturation at LIMIT is implicit:
      // at LIMIT a waiting aux always wins, which clears the count.
      starve_d = starve_q;
      if ((decision == DEC_AUX) || !AuxAluReq) begin
         starve_d = 4'd0;
      end else if ((decision == DEC_PIPE) && (starve_q != LIMIT)) begin
         starve_d = starve_q + 4'd1;
      end
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         ctrl_q   <= 8'h00;
         active_q <= 1'b0;
         owner_q  <= 2'b00;
         starve_q <= 4'd0;
      end else begin
         ctrl_q   <= ctrl_d;
         active_q <= active_d;
         owner_q  <= owner_d;
         starve_q <= starve_d;
      end
   end

   assign AluCtrl   = ctrl_q;
   assign AluActive = active_q;
   assign AluOwner  = owner_q;

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// -----------------------------------------------------------------------------
// Testbench for alu_issue_arbiter: directed scenarios followed by randomized
// traffic, all checked against a behavioural model of the arbitration rules.
// -----------------------------------------------------------------------------
module tb_alu_issue_arbiter;

   localparam int LIMIT = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       pipe_req = 1'b0;
   logic [3:0] pipe_op = 4'h0;
   logic       aux_req = 1'b0;
   logic [3:0] aux_op = 4'h0;
   logic       stall, gnt, act;
   logic [7:0] ctrl;
   logic [1:0] own;

   always #5 clk = ~clk;

   alu_issue_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
      .Clock       (clk),
      .Reset       (rst),
      .PipeAluReq  (pipe_req),
      .PipeAluOp   (pipe_op),
      .PipeAluStall(stall),
      .AuxAluReq   (aux_req),
      .AuxAluOp    (aux_op),
      .AuxAluGnt   (gnt),
      .AluCtrl     (ctrl),
      .AluActive   (act),
      .AluOwner    (own)
   );

   int n_vec = 0;
   int n_err = 0;

   // Behavioural model state
   logic [7:0] m_ctrl = 8'h00;
   logic       m_act  = 1'b0;
   logic [1:0] m_own  = 2'b00;
   int         m_wait = 0;     // pipeline wins in a row while aux waits
   logic       m_aux_w, m_pipe_w;
   logic       seen_gnt;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Default ROM: entry n is n repeated in both nibbles.
   function automatic logic [7:0] rom(input logic [3:0] op);
      return {op, op};
   endfunction

   // One clock: check at the falling edge, advance model at the rising edge,
   // then return 1 time unit after the edge so the caller can drive inputs.
   task automatic cycle();
      @(negedge clk);
      if (rst) begin
         m_ctrl = 8'h00; m_act = 1'b0; m_own = 2'b00; m_wait = 0;
      end
      m_aux_w  = !rst && aux_req && (!pipe_req || m_wait == LIMIT);
      m_pipe_w = !rst && pipe_req && !m_aux_w;
      seen_gnt = gnt;
      chk("gnt",   {7'b0, gnt},   {7'b0, m_aux_w});
      chk("stall", {7'b0, stall}, {7'b0, pipe_req && m_aux_w});
      chk("ctrl",  ctrl, m_ctrl);
      chk("act",   {7'b0, act},   {7'b0, m_act});
      chk("owner", {6'b0, own},   {6'b0, m_own});
      @(posedge clk);
      if (!rst) begin
         if (m_aux_w) begin
            m_ctrl = rom(aux_op); m_act = 1'b1; m_own = 2'b10; m_wait = 0;
         end else if (m_pipe_w) begin
            m_ctrl = rom(pipe_op); m_act = 1'b1; m_own = 2'b01;
            m_wait = aux_req ? m_wait + 1 : 0;
         end else begin
            m_act = 1'b0; m_own = 2'b00; m_wait = 0;
         end
      end
      #1;
   endtask

   logic [3:0] ops [3];
   logic       exp_starve [10];
   logic       exp_clear  [5];

   initial begin
      ops = '{4'h0, 4'h5, 4'hF};
      exp_starve = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
      exp_clear  = '{0, 0, 0, 0, 1};

      // Reset with both requests high
      pipe_req = 1'b1; aux_req = 1'b1; pipe_op = 4'h7; aux_op = 4'h7;
      #1;
      cycle();
      chk("rst_gnt", {7'b0, gnt}, 8'h00);
      cycle();
      pipe_req = 1'b0; aux_req = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      cycle();

      // Pipeline stream 0,5,F then idle
      for (int i = 0; i < 3; i++) begin
         pipe_req = 1'b1; pipe_op = ops[i];
         cycle();
      end
      pipe_req = 1'b0;
      cycle();
      chk("stream_last", ctrl, 8'hFF);
      cycle();

      // Aux alone then idle; AluCtrl must hold 33
      aux_req = 1'b1; aux_op = 4'h3;
      cycle();
      chk("aux_alone_gnt", {7'b0, seen_gnt}, 8'h01);
      aux_req = 1'b0;
      cycle();
      chk("aux_alone_ctrl", ctrl, 8'h33);
      cycle();
      chk("idle_hold", ctrl, 8'h33);

      // Continuous contention: aux forced through every fifth cycle
      pipe_req = 1'b1; pipe_op = 4'h1; aux_req = 1'b1; aux_op = 4'h9;
      for (int i = 0; i < 10; i++) begin
         cycle();
         chk("starve_seq", {7'b0, seen_gnt}, {7'b0, exp_starve[i]});
      end
      aux_req = 1'b0; pipe_req = 1'b0;
      cycle();

      // Counter restarts after aux drops its request
      pipe_req = 1'b1; pipe_op = 4'h2; aux_req = 1'b1; aux_op = 4'hA;
      cycle(); cycle();
      aux_req = 1'b0;
      cycle();
      aux_req = 1'b1;
      for (int i = 0; i < 5; i++) begin
         cycle();
         chk("clear_seq", {7'b0, seen_gnt}, {7'b0, exp_clear[i]});
      end
      pipe_req = 1'b0; aux_req = 1'b0;
      cycle();

      // Reset in the aux grant cycle; grant comes on first post-reset cycle
      aux_req = 1'b1; aux_op = 4'hC;
      #1 rst = 1'b1;
      cycle();
      chk("midrst_owner", {6'b0, own}, 8'h00);
      chk("midrst_gnt", {7'b0, seen_gnt}, 8'h00);
      rst = 1'b0;
      cycle();
      chk("postrst_gnt", {7'b0, seen_gnt}, 8'h01);
      aux_req = 1'b0;
      cycle();
      chk("postrst_ctrl", ctrl, 8'hCC);

      // Randomized traffic obeying the requester protocols
      for (int i = 0; i < 2000; i++) begin
         if (rst) begin
            rst = 1'b0;
         end else if ($urandom_range(0, 199) == 0) begin
            #1 rst = 1'b1;
         end
         cycle();
         // A stalled pipeline op is held; otherwise pick a fresh one.
         if (!(pipe_req && m_aux_w) || rst) begin
            pipe_req = ($urandom_range(0, 3) != 0);
            pipe_op  = 4'($urandom);
         end
         // Aux holds its request until granted.
         if (!aux_req || m_aux_w || rst) begin
            aux_req = ($urandom_range(0, 2) == 0);
            aux_op  = 4'($urandom);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/alu_issue_arbiter.md
# alu_issue_arbiter

Registered issue stage in front of the ALU. Arbitrates the shared ALU between the main pipeline (stage-1 ALU op) and an auxiliary requester (debug/interrupt microsequencer). Decodes the winning 4-bit ALU op into the 8-bit ALU control word (AC0..AC7). Drives the ALU active/clock-enable strobe, with a starvation guard so the auxiliary requester is always served.

## Interface
- STARVE_LIMIT, 4: consecutive pipeline grants allowed while aux is waiting before aux is forced through; legal 1..15.
- DECODE_ROM, 128'hFFEEDDCCBBAA99887766554433221100: op-to-control table; entry n is DECODE_ROM[8n+7:8n]. The top level overrides the default.

Ports:
- Clock  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-high reset.
- PipeAluReq  in  1  pipeline has an ALU op this cycle.
- PipeAluOp  in  4  pipeline ALU op (ALUOP3..0).
- PipeAluStall  out  1  combinational; pipeline op not accepted, hold it.
- AuxAluReq  in  1  aux requester has an op; held until granted.
- AuxAluOp  in  4  aux ALU op; stable while AuxAluReq=1.
- AuxAluGnt  out  1  combinational, one-cycle accept pulse for aux.
- AluCtrl  out  8  registered control word; bit0..7 = AC0_RHS0..AC7_CS1.
- AluActive  out  1  registered; ALU performs the issued op this cycle.
- AluOwner  out  2  registered; 00 idle, 01 pipeline, 10 aux, 11 unused.

## Operation
- Per cycle, the combinational decision selects one of IDLE, PIPE or AUX:
  - IDLE when no request is present.
  - PIPE when PipeAluReq=1 and not (AuxAluReq=1 and starve_cnt==STARVE_LIMIT).
  - AUX when AuxAluReq=1 and (PipeAluReq=0 or starve_cnt==STARVE_LIMIT).
- PipeAluStall = PipeAluReq & (decision==AUX).
- AuxAluGnt = (decision==AUX).
- On the clock edge:
  - PIPE/AUX: AluCtrl <= DECODE_ROM entry of the winner's op; AluActive <= 1; AluOwner <= 01/10.
  - IDLE: AluActive <= 0; AluOwner <= 00; AluCtrl holds its previous value (no toggling).
- starve_cnt is 4 bits and internal:
  - Increments when decision==PIPE and AuxAluReq=1, saturating at STARVE_LIMIT.
  - Clears to 0 when decision==AUX or AuxAluReq=0.
- An aux op issues exactly once per request. The aux requester deasserts AuxAluReq, or presents the next op, the cycle after AuxAluGnt.
- Ops are single-cycle; there is no multi-cycle hold. Back-to-back issue at one op per cycle from either source is required.
- Op values are unrestricted: all 16 entries are decoded with no illegal-op handling.

## Timing
- Reset (asynchronous assert, edge-aligned deassert) forces:
  - AluCtrl=8'h00, AluActive=0, AluOwner=00, starve_cnt=0.
  - PipeAluStall=0 and AuxAluGnt=0 while Reset=1, regardless of requests.
- Latency: a request accepted in cycle N appears on AluCtrl/AluActive/AluOwner in cycle N+1. Grant/stall are same-cycle (cycle N).
- A stalled pipeline op is re-presented in N+1 and is guaranteed acceptance there, because starve_cnt has just cleared.
- Reset asserted mid-stream drops any accepted-but-unissued op. Outputs go to reset values immediately, and no grant is reissued after reset; requesters re-request.
- Simultaneous requests with starve_cnt<STARVE_LIMIT: pipeline wins, aux waits.
- Simultaneous requests with starve_cnt==STARVE_LIMIT: aux wins, pipeline stalls exactly one cycle.
- Aux alone: granted in the same cycle it is requested.
- STARVE_LIMIT=1 yields strict alternation under continuous contention.

## Test plan
- Reset: assert Reset with both requests high, op 4'h7 → AluCtrl=00, AluActive=0, AluOwner=00, AuxAluGnt=0, PipeAluStall=0.
- Pipeline stream: PipeAluReq=1 with ops 0,5,F on consecutive cycles, default ROM → AluCtrl 00,55,FF one cycle later, AluActive=1, AluOwner=01, PipeAluStall never asserted.
- Aux alone: AuxAluReq=1, op 4'h3, pipe idle → AuxAluGnt=1 same cycle, next cycle AluCtrl=33, AluOwner=10; then idle → AluActive=0, AluCtrl stays 33.
- Starvation, STARVE_LIMIT=4: both requesting continuously, pipe op 1, aux op 9 → owner sequence 01,01,01,01,10,01,01,01,01,10; PipeAluStall high only in the aux-grant cycles.
- Counter clear: aux requests for 2 pipe-grant cycles, drops for 1, re-requests → the count restarts, so aux waits a full 4 pipe grants.
- Mid-stream reset: assert Reset in the cycle aux is granted → AluOwner=00, no AuxAluGnt during reset; after release with AuxAluReq held, the grant occurs on the first post-reset cycle.
